// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bus between a load/store client (master) and data_mem_ctrl (slave)
// Ports: req_valid/req_ready handshake, req_we (1 = store), req_funct3 (RISC-V size/sign code),
//        req_addr (byte address), req_wdata (LSB-aligned store data), resp_valid (one-cycle strobe),
//        resp_rdata (extended load result), resp_err (access rejected, valid with resp_valid)
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed little-endian data memory with RISC-V load/store decoding and fixed latency
// Ports: clk (rising-edge clock), rst (async active-high reset), bus (data_mem_ctrl_if.slave request/response)
// Macro DMEM_MISALIGN_CHECK_EN: when defined, misaligned halfword/word accesses are rejected with resp_err;
// otherwise they are carried out byte-by-byte.
module data_mem_ctrl #(
  parameter int DEPTH_BYTES = 2048,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH_BYTES);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic [7:0]            mem_q [DEPTH_BYTES];
  logic                  we_e;
  logic [2:0]            f3_e;
  logic [ADDR_WIDTH-1:0] addr_e;
  logic [31:0]           wdata_e;
  logic [2:0]            sz;
  logic [ADDR_WIDTH:0]   end_a;
  logic                  bad_f3, oob, mis, err, sgn, go_resp, wr_en, cap;
  logic [AW-1:0]         idx;
  logic [7:0]            byte_r [4];
  logic [31:0]           ld;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        cap     = 1'b1;
        state_d = WAIT_CYCLES > 0 ? S_WAIT : S_RESP;
        cnt_d   = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
      end
      S_WAIT: begin
        state_d = cnt_q == 4'd0 ? S_RESP : S_WAIT;
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // With WAIT_CYCLES = 0 the response is built straight from the bus, before the capture registers load.
  always_comb begin
    we_e    = state_q == S_IDLE ? bus.req_we : we_q;
    f3_e    = state_q == S_IDLE ? bus.req_funct3 : f3_q;
    addr_e  = state_q == S_IDLE ? bus.req_addr : addr_q;
    wdata_e = state_q == S_IDLE ? bus.req_wdata : wdata_q;
    sz      = f3_e[1:0] == 2'd0 ? 3'd1 : f3_e[1:0] == 2'd1 ? 3'd2 : 3'd4;
    bad_f3  = (&f3_e[1:0]) | (we_e ? f3_e[2] : &f3_e[2:1]);
    end_a   = {1'b0, addr_e} + (ADDR_WIDTH+1)'(sz);
    oob     = end_a > (ADDR_WIDTH+1)'(DEPTH_BYTES);
`ifdef DMEM_MISALIGN_CHECK_EN
    mis     = (f3_e[1:0] == 2'd1 & addr_e[0]) | (f3_e[1:0] == 2'd2 & |addr_e[1:0]);
`else
    mis     = 1'b0;
`endif
    err     = bad_f3 | oob | mis;
    sgn     = ~f3_e[2];
    idx     = addr_e[AW-1:0];
    for (int i = 0; i < 4; i++) byte_r[i] = mem_q[idx + AW'(i)];
    ld      = sz == 3'd1 ? {{24{sgn & byte_r[0][7]}}, byte_r[0]} :
              sz == 3'd2 ? {{16{sgn & byte_r[1][7]}}, byte_r[1], byte_r[0]} :
                           {byte_r[3], byte_r[2], byte_r[1], byte_r[0]};
    go_resp = state_d == S_RESP;
    // rst gates the commit so a reset landing on the RESP-entry edge aborts the store
    wr_en   = go_resp & we_e & ~err & ~rst;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (go_resp) begin
        err_q   <= err;
        rdata_q <= (err | we_e) ? 32'd0 : ld;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < 4; i++)
        if (i < int'(sz)) mem_q[idx + AW'(i)] <= wdata_e[8*i +: 8];
  end
  assign bus.req_ready  = state_q == S_IDLE;
  assign bus.resp_valid = state_q == S_RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl with WAIT_CYCLES=1 and WAIT_CYCLES=3 instances
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  data_mem_ctrl_if #(.ADDR_WIDTH(32)) b1();
  data_mem_ctrl_if #(.ADDR_WIDTH(32)) b3();
  data_mem_ctrl #(.DEPTH_BYTES(2048), .ADDR_WIDTH(32), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  data_mem_ctrl #(.DEPTH_BYTES(2048), .ADDR_WIDTH(32), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic        er;
  int          lat;
  task automatic set_req(input bit d3, input logic v, input logic we, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd);
    if (d3) begin
      b3.req_valid = v; b3.req_we = we; b3.req_funct3 = f; b3.req_addr = a; b3.req_wdata = wd;
    end else begin
      b1.req_valid = v; b1.req_we = we; b1.req_funct3 = f; b1.req_addr = a; b1.req_wdata = wd;
    end
  endtask
  function automatic logic rdy(input bit d3);
    return d3 ? b3.req_ready : b1.req_ready;
  endfunction
  function automatic logic rv(input bit d3);
    return d3 ? b3.resp_valid : b1.resp_valid;
  endfunction
  // Issues one request (held until accepted) and returns the response plus the
  // latency in cycles from the acceptance cycle to the resp_valid cycle.
  task automatic xact(input bit d3, input logic we, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rdo, output logic ero, output int lato);
    int n;
    @(negedge clk);
    set_req(d3, 1'b1, we, f, a, wd);
    n = 0;
    while (!rdy(d3) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout addr=%h ready=0 required=1", a);
    end
    @(posedge clk);
    #1;
    set_req(d3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    lato = 1;
    while (!rv(d3) && lato < 40) begin
      @(posedge clk);
      #1;
      lato++;
    end
    rdo = d3 ? b3.resp_rdata : b1.resp_rdata;
    ero = d3 ? b3.resp_err : b1.resp_err;
  endtask
  task automatic test_reset;
    set_req(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({b1.req_ready, b1.resp_valid, b1.resp_err} !== 3'b100 || b1.resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_dut1 ready/valid/err=%b rdata=%h required 100 00000000",
               {b1.req_ready, b1.resp_valid, b1.resp_err}, b1.resp_rdata);
    end
    checks++;
    if ({b3.req_ready, b3.resp_valid, b3.resp_err} !== 3'b100 || b3.resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_dut3 ready/valid/err=%b rdata=%h required 100 00000000",
               {b3.req_ready, b3.resp_valid, b3.resp_err}, b3.resp_rdata);
    end
    rst = 1'b0;
  endtask
  task automatic test_store_load;
    xact(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL sw_0x10 rdata=%h err=%b lat=%0d required 00000000 0 2", rd, er, lat);
    end
    xact(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL lw_0x10 rdata=%h err=%b lat=%0d required deadbeef 0 2", rd, er, lat);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b1.resp_rdata !== 32'hDEADBEEF || b1.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdata_hold rdata=%h valid=%b required deadbeef 0", b1.resp_rdata, b1.resp_valid);
    end
  endtask
  task automatic test_load_ext;
    logic [2:0]  f [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] a [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    logic [31:0] e [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, 1'b0, f[i], a[i], 32'h0, rd, er, lat);
      checks++;
      if (rd !== e[i] || er !== 1'b0 || lat !== 2) begin
        errors++;
        $display("FAIL load_ext[%0d] rdata=%h err=%b lat=%0d required %h 0 2", i, rd, er, lat, e[i]);
      end
    end
  endtask
  task automatic test_misalign;
    xact(1'b0, 1'b0, 3'b001, 32'h11, 32'h0, rd, er, lat);
    checks++;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (rd !== 32'd0 || er !== 1'b1) begin
      errors++;
      $display("FAIL lh_0x11 rdata=%h err=%b required 00000000 1", rd, er);
    end
`else
    if (rd !== 32'hFFFFADBE || er !== 1'b0) begin
      errors++;
      $display("FAIL lh_0x11 rdata=%h err=%b required ffffadbe 0", rd, er);
    end
`endif
  endtask
  task automatic test_byte_store;
    xact(1'b0, 1'b1, 3'b000, 32'h11, 32'h00000055, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      errors++;
      $display("FAIL sb_0x11 rdata=%h err=%b required 00000000 0", rd, er);
    end
    xact(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
      errors++;
      $display("FAIL lw_after_sb rdata=%h err=%b required dead55ef 0", rd, er);
    end
  endtask
  task automatic test_errors;
    logic        we [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f  [7] = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b011, 3'b100};
    logic [31:0] a  [7] = '{32'h7FC, 32'h7FE, 32'h800, 32'h80000010, 32'h80000010, 32'h10, 32'h7FC};
    logic [31:0] wd [7] = '{32'h12345678, 0, 32'hAAAAAAAA, 0, 32'h0, 0, 32'h0};
    logic        ee [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      xact(1'b0, we[i], f[i], a[i], wd[i], rd, er, lat);
      checks++;
      if (rd !== 32'd0 || er !== ee[i] || lat !== 2) begin
        errors++;
        $display("FAIL err_case[%0d] rdata=%h err=%b lat=%0d required 00000000 %b 2", i, rd, er, lat, ee[i]);
      end
    end
    xact(1'b0, 1'b0, 3'b010, 32'h7FC, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      errors++;
      $display("FAIL lw_0x7fc_unchanged rdata=%h err=%b required 12345678 0", rd, er);
    end
    xact(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
      errors++;
      $display("FAIL lw_0x10_unchanged rdata=%h err=%b required dead55ef 0", rd, er);
    end
  endtask
  task automatic test_reset_in_wait;
    int n;
    logic seen;
    xact(1'b1, 1'b1, 3'b010, 32'h20, 32'h11223344, rd, er, lat);
    checks++;
    if (er !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL w3_sw_0x20 err=%b lat=%0d required 0 4", er, lat);
    end
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b1, 3'b010, 32'h20, 32'h99999999);
    n = 0;
    while (!b3.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    set_req(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    checks++;
    if (b3.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL w3_in_wait ready=%b required 0", b3.req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (b3.req_ready !== 1'b1 || b3.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL w3_rst_abort ready=%b valid=%b required 1 0", b3.req_ready, b3.resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen = seen | b3.resp_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL w3_no_resp resp_valid_seen=%b required 0", seen);
    end
    xact(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11223344 || er !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL w3_lw_0x20 rdata=%h err=%b lat=%0d required 11223344 0 4", rd, er, lat);
    end
    xact(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
      errors++;
      $display("FAIL mem_kept_over_reset rdata=%h err=%b required dead55ef 0", rd, er);
    end
  endtask
  initial begin
    test_reset;
    test_store_load;
    test_load_ext;
    test_misalign;
    test_byte_store;
    test_errors;
    test_reset_in_wait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 2048, meaning byte storage size (power of two, 4..65536).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning request address width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, meaning extra access latency cycles (0..15).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, block can accept a request.
REQ-008 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_funct3, input, 3, RISC-V load/store funct3 size/sign code.
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH, byte address.
REQ-011 SHALL have port req_wdata, input, 32, store data (LSB-aligned).
REQ-012 SHALL have port resp_valid, output, 1, one-cycle response strobe.
REQ-013 SHALL have port resp_rdata, output, 32, load result, extended to 32 bits.
REQ-014 SHALL have port resp_err, output, 1, access rejected; valid with resp_valid.

Function
REQ-015 SHALL store bytes little-endian: byte at addr = bits 7:0, addr+1 = 15:8, addr+2 = 23:16, addr+3 = 31:24.
REQ-016 SHALL implement FSM IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL capture we/funct3/addr/wdata on req_valid & req_ready, then go to WAIT if WAIT_CYCLES > 0, else to RESP.
REQ-018 SHALL stay in WAIT exactly WAIT_CYCLES cycles via a down-counter, then go to RESP.
REQ-019 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; acceptance-to-resp_valid latency = WAIT_CYCLES+1 cycles; no response back-pressure.
REQ-020 SHALL decode loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-021 SHALL decode stores: 000 SB, 001 SH, 010 SW, writing only the addressed 1/2/4 bytes.
REQ-022 SHALL commit store bytes on the clock edge that enters RESP; load data SHALL reflect memory as of that edge.
REQ-023 SHALL flag resp_err for an unsupported funct3 (loads 011/110/111, stores 011..111).
REQ-024 SHALL flag resp_err when addr + access size > DEPTH_BYTES (upper address bits included).
REQ-025 SHALL, on resp_err: perform no write and drive resp_rdata = 0.
REQ-026 SHALL hold resp_rdata and resp_err until the next RESP; stores SHALL return resp_rdata = 0.
REQ-027 SHALL ignore req_valid outside IDLE; a request held through WAIT/RESP SHALL be accepted on return to IDLE.

Reset
REQ-028 SHALL on rst go to IDLE with counter = 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-029 SHALL, when rst asserts in WAIT, abort the access with no write and no response.
REQ-030 SHALL not clear memory contents on reset.

Configuration
REQ-031 SHALL honour macro DMEM_MISALIGN_CHECK_EN: defined -> halfword with addr[0] != 0, or word with addr[1:0] != 0, gives resp_err, no write.
REQ-032 SHALL, without DMEM_MISALIGN_CHECK_EN, perform misaligned accesses byte-by-byte at addr..addr+size-1 per REQ-015, with no error unless REQ-023/REQ-024 apply.

Verification
REQ-033 SHALL cover: WAIT_CYCLES=1, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata 0xDEADBEEF, resp_valid 2 cycles after each acceptance, resp_err 0.
REQ-034 SHALL cover: after REQ-033, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-035 SHALL cover: SB 0x11 data 0x00000055 over 0xDEADBEEF -> LW 0x10 returns 0xDEAD55EF.
REQ-036 SHALL cover: LW 0x7FE with DEPTH_BYTES=2048 -> resp_err 1, rdata 0; SW 0x800 -> resp_err 1, memory unchanged.
REQ-037 SHALL cover: LH 0x11 -> with DMEM_MISALIGN_CHECK_EN resp_err 1; without it rdata 0xFFFFADBE from memory 0xDEADBEEF at 0x10.
REQ-038 SHALL cover: WAIT_CYCLES=3, SW 0x20 accepted, rst pulsed in WAIT -> no resp_valid, req_ready 1, LW 0x20 returns prior contents.
